// File: rtl/lab2_proc_mem_responder_pkg.sv
// Shared memory-message package: request/response structs, message type
// encodings and the byte-lane helpers used by the responder.
package lab2_proc_mem_responder_pkg;

    localparam logic [2:0] MEM_TYPE_READ  = 3'd0;
    localparam logic [2:0] MEM_TYPE_WRITE = 3'd1;
    localparam logic [2:0] MEM_TYPE_INIT  = 3'd2;

    typedef struct packed {
        logic [2:0]  msg_type;
        logic [7:0]  opaque;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_req_4B_t;

    typedef struct packed {
        logic [2:0]  msg_type;
        logic [7:0]  opaque;
        logic [1:0]  test;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_resp_4B_t;

    // Init behaves exactly like a write.
    function automatic logic is_store(input logic [2:0] msg_type);
        return (msg_type == MEM_TYPE_WRITE) || (msg_type == MEM_TYPE_INIT);
    endfunction

    // Bytes covered by an access of the given len, counted from lane 0.
    function automatic logic [3:0] size_keep(input logic [1:0] len);
        case (len)
            2'd1:    return 4'b0001;
            2'd2:    return 4'b0011;
            2'd3:    return 4'b0111;
            default: return 4'b1111;
        endcase
    endfunction

    // First byte lane of the access: bytes use addr[1:0], halfwords addr[1],
    // full words and 3-byte accesses always start at lane 0.
    function automatic logic [1:0] lane_offset(input logic [1:0] len, input logic [1:0] off);
        case (len)
            2'd1:    return off;
            2'd2:    return {off[1], 1'b0};
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/lab2_proc_mem_responder_lane_align.sv
// Byte-lane masking and alignment: places write data onto its lanes with a
// byte enable, and pulls read data down to bit 0 with zero extension.
module lab2_proc_mem_responder_lane_align
    import lab2_proc_mem_responder_pkg::*;
(
    input  logic [1:0]  wr_len,
    input  logic [1:0]  wr_off,
    input  logic [31:0] wr_data,
    output logic [3:0]  wr_be,
    output logic [31:0] wr_lanes,
    input  logic [1:0]  rd_len,
    input  logic [1:0]  rd_off,
    input  logic [31:0] rd_word,
    output logic [31:0] rd_data
);

    logic [1:0]  wr_shift;
    logic [1:0]  rd_shift;
    logic [3:0]  rd_keep;
    logic [31:0] wr_shifted;
    logic [31:0] rd_shifted;

    assign wr_shift   = lane_offset(wr_len, wr_off);
    assign rd_shift   = lane_offset(rd_len, rd_off);
    assign wr_be      = size_keep(wr_len) << wr_shift;
    assign rd_keep    = size_keep(rd_len);
    assign wr_shifted = wr_data << {wr_shift, 3'b000};
    assign rd_shifted = rd_word >> {rd_shift, 3'b000};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign wr_lanes[gi*8 +: 8] = wr_be[gi]   ? wr_shifted[gi*8 +: 8] : 8'h00;
            assign rd_data[gi*8 +: 8]  = rd_keep[gi] ? rd_shifted[gi*8 +: 8] : 8'h00;
        end
    endgenerate

endmodule

// File: rtl/lab2_proc_mem_responder.sv
// Test memory responder: val/rdy request stream in, fixed-latency response
// stream out, word storage with byte-masked writes.
// Optional build macro LAB2_PROC_MEM_RESPONDER_STATS_EN adds the num_reads /
// num_writes request counters as extra outputs.
module lab2_proc_mem_responder
    import lab2_proc_mem_responder_pkg::*;
#(
    parameter int p_mem_nwords = 256,
    parameter int p_latency    = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         reqstream_val,
    output logic         reqstream_rdy,
    input  mem_req_4B_t  reqstream_msg,
    output logic         respstream_val,
    input  logic         respstream_rdy,
    output mem_resp_4B_t respstream_msg
`ifdef LAB2_PROC_MEM_RESPONDER_STATS_EN
    ,
    output logic [31:0]  num_reads,
    output logic [31:0]  num_writes
`endif
);

    localparam int         IDX_W      = $clog2(p_mem_nwords);
    localparam logic [3:0] DELAY_LOAD = 4'((p_latency > 0) ? p_latency - 1 : 0);

    typedef enum logic [1:0] {IDLE, DELAY, RESP} state_t;

    state_t            state_reg, state_next;
    logic [3:0]        delay_cnt_reg, delay_cnt_next;
    logic              req_fire, resp_fire;
    logic              req_store;
    logic [IDX_W-1:0]  req_idx;
    logic [3:0]        wr_be;
    logic [31:0]       wr_lanes;
    logic [31:0]       rd_data;
    logic              unused_addr;

    logic [31:0]       mem [p_mem_nwords];
    logic [31:0]       rd_word_reg;
    logic [2:0]        resp_type_reg;
    logic [7:0]        resp_opaque_reg;
    logic [1:0]        resp_len_reg;
    logic [1:0]        resp_off_reg;
    logic              resp_read_reg;

    // Upper address bits are dropped on purpose so addresses wrap.
    assign req_idx     = reqstream_msg.addr[2 +: IDX_W];
    assign req_store   = is_store(reqstream_msg.msg_type);
    assign unused_addr = ^reqstream_msg.addr;

    lab2_proc_mem_responder_lane_align lane_align (
        .wr_len   (reqstream_msg.len),
        .wr_off   (reqstream_msg.addr[1:0]),
        .wr_data  (reqstream_msg.data),
        .wr_be    (wr_be),
        .wr_lanes (wr_lanes),
        .rd_len   (resp_len_reg),
        .rd_off   (resp_off_reg),
        .rd_word  (rd_word_reg),
        .rd_data  (rd_data)
    );

    // Handshake outputs and next-state: a new request may be accepted while
    // the current response retires, giving one response per cycle at latency 0.
    always_comb begin
        reqstream_rdy  = 1'b0;
        respstream_val = 1'b0;
        state_next     = state_reg;
        delay_cnt_next = delay_cnt_reg;
        case (state_reg)
            IDLE:    reqstream_rdy = 1'b1;
            RESP: begin
                respstream_val = 1'b1;
                reqstream_rdy  = respstream_rdy;
            end
            default: ;
        endcase
        req_fire  = reqstream_val & reqstream_rdy;
        resp_fire = respstream_val & respstream_rdy;
        case (state_reg)
            DELAY: begin
                if (delay_cnt_reg == 4'd0) state_next = RESP;
                else                       delay_cnt_next = delay_cnt_reg - 4'd1;
            end
            RESP:    if (resp_fire) state_next = IDLE;
            default: ;
        endcase
        if (req_fire) begin
            if (p_latency == 0) begin
                state_next = RESP;
            end else begin
                state_next     = DELAY;
                delay_cnt_next = DELAY_LOAD;
            end
        end
    end

    // State and delay counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            delay_cnt_reg <= 4'd0;
        end else begin
            state_reg     <= state_next;
            delay_cnt_reg <= delay_cnt_next;
        end
    end

    // Storage: byte-masked write or registered read on the accept cycle; the
    // read word is captured here so later writes cannot disturb the response.
    always_ff @(posedge clk) begin
        if (req_fire && !reset) begin
            if (req_store) begin
                for (int b = 0; b < 4; b++) begin
                    if (wr_be[b]) mem[req_idx][b*8 +: 8] <= wr_lanes[b*8 +: 8];
                end
            end else begin
                rd_word_reg <= mem[req_idx];
            end
        end
    end

    // Response header register, loaded with the accepted request's fields.
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_type_reg   <= 3'd0;
            resp_opaque_reg <= 8'd0;
            resp_len_reg    <= 2'd0;
            resp_off_reg    <= 2'd0;
            resp_read_reg   <= 1'b0;
        end else if (req_fire) begin
            resp_type_reg   <= reqstream_msg.msg_type;
            resp_opaque_reg <= reqstream_msg.opaque;
            resp_len_reg    <= reqstream_msg.len;
            resp_off_reg    <= reqstream_msg.addr[1:0];
            resp_read_reg   <= !req_store;
        end
    end

    // Response message; store responses carry zero data.
    always_comb begin
        respstream_msg          = '0;
        respstream_msg.msg_type = resp_type_reg;
        respstream_msg.opaque   = resp_opaque_reg;
        respstream_msg.test     = 2'd0;
        respstream_msg.len      = resp_len_reg;
        respstream_msg.data     = resp_read_reg ? rd_data : 32'd0;
    end

`ifdef LAB2_PROC_MEM_RESPONDER_STATS_EN
    logic [31:0] num_reads_reg;
    logic [31:0] num_writes_reg;

    // Request counters, free-running with natural 32-bit wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            num_reads_reg  <= 32'd0;
            num_writes_reg <= 32'd0;
        end else if (req_fire) begin
            if (req_store) num_writes_reg <= num_writes_reg + 32'd1;
            else           num_reads_reg  <= num_reads_reg + 32'd1;
        end
    end

    assign num_reads  = num_reads_reg;
    assign num_writes = num_writes_reg;
`endif

endmodule

// File: tb/tb_lab2_proc_mem_responder.sv
// Self-checking bench for lab2_proc_mem_responder: directed vector table,
// backpressure / back-to-back / reset corner cases, then random traffic
// checked against a byte-addressed memory model.
module tb_lab2_proc_mem_responder;
    import lab2_proc_mem_responder_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // Instance "a": latency 1; instance "b": latency 0.
    logic         a_req_val, a_req_rdy, a_resp_val, a_resp_rdy;
    mem_req_4B_t  a_req_msg;
    mem_resp_4B_t a_resp_msg;
    logic         b_req_val, b_req_rdy, b_resp_val, b_resp_rdy;
    mem_req_4B_t  b_req_msg;
    mem_resp_4B_t b_resp_msg;
`ifdef LAB2_PROC_MEM_RESPONDER_STATS_EN
    logic [31:0]  a_num_reads, a_num_writes, b_num_reads, b_num_writes;
`endif

    lab2_proc_mem_responder #(.p_mem_nwords(256), .p_latency(1)) dut_a (
        .clk(clk), .reset(reset),
        .reqstream_val(a_req_val), .reqstream_rdy(a_req_rdy), .reqstream_msg(a_req_msg),
        .respstream_val(a_resp_val), .respstream_rdy(a_resp_rdy), .respstream_msg(a_resp_msg)
`ifdef LAB2_PROC_MEM_RESPONDER_STATS_EN
        , .num_reads(a_num_reads), .num_writes(a_num_writes)
`endif
    );

    lab2_proc_mem_responder #(.p_mem_nwords(256), .p_latency(0)) dut_b (
        .clk(clk), .reset(reset),
        .reqstream_val(b_req_val), .reqstream_rdy(b_req_rdy), .reqstream_msg(b_req_msg),
        .respstream_val(b_resp_val), .respstream_rdy(b_resp_rdy), .respstream_msg(b_resp_msg)
`ifdef LAB2_PROC_MEM_RESPONDER_STATS_EN
        , .num_reads(b_num_reads), .num_writes(b_num_writes)
`endif
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int a_reads      = 0;
    int a_writes     = 0;

    logic [7:0] model_mem [1024];

    typedef struct {
        logic [2:0]  t;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
        logic [7:0]  op;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [19];

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Model: memory seen as 1024 bytes, word index wraps modulo 256 words.
    function automatic void span(input logic [31:0] addr, input logic [1:0] len,
                                 output int base, output int off, output int n);
        base = int'((addr >> 2) & 32'd255) * 4;
        case (len)
            2'd0:    begin off = 0;                n = 4; end
            2'd1:    begin off = int'(addr[1:0]);  n = 1; end
            2'd2:    begin off = addr[1] ? 2 : 0;  n = 2; end
            default: begin off = 0;                n = 3; end
        endcase
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] addr, input logic [1:0] len);
        int base, off, n;
        logic [31:0] r;
        span(addr, len, base, off, n);
        r = 32'd0;
        for (int k = 0; k < n; k++) r = r | (32'(model_mem[base + off + k]) << (8 * k));
        return r;
    endfunction

    function automatic void model_write(input logic [31:0] addr, input logic [1:0] len, input logic [31:0] data);
        int base, off, n;
        span(addr, len, base, off, n);
        for (int k = 0; k < n; k++) model_mem[base + off + k] = data[8*k +: 8];
    endfunction

    // One request/response on instance a; entered and left at a falling edge.
    task automatic do_txn(input mem_req_4B_t req, input int hold,
                          output mem_resp_4B_t resp, output int lat, output logic ok);
        int waits;
        waits = 0;
        ok = 1'b0; resp = '0; lat = 0;
        a_resp_rdy = 1'b0;
        a_req_msg  = req;
        a_req_val  = 1'b1;
        #1;
        while (!a_req_rdy && waits < 20) begin
            @(negedge clk); #1; waits++;
        end
        if (!a_req_rdy) begin
            check("req_accept_timeout", 64'd0, 64'd1);
            a_req_val = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        a_req_val = 1'b0;
        lat = 1;
        while (!a_resp_val && lat < 40) begin
            @(negedge clk); lat++;
        end
        if (!a_resp_val) begin
            check("resp_timeout", 64'd0, 64'd1);
            return;
        end
        resp = a_resp_msg;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_val", 64'(a_resp_val), 64'd1);
            check("hold_msg_stable", 64'(a_resp_msg), 64'(resp));
            check("hold_req_rdy_low", 64'(a_req_rdy), 64'd0);
        end
        a_resp_rdy = 1'b1;
        #1;
        check("req_rdy_with_resp_rdy", 64'(a_req_rdy), 64'd1);
        @(posedge clk);
        @(negedge clk);
        a_resp_rdy = 1'b0;
        check("resp_retired", 64'(a_resp_val), 64'd0);
        ok = 1'b1;
    endtask

    task automatic apply(input string tag, input logic [2:0] t, input logic [31:0] addr,
                         input logic [1:0] len, input logic [31:0] data, input logic [7:0] op,
                         input int hold, input logic [31:0] exp_data);
        mem_req_4B_t  req;
        mem_resp_4B_t resp;
        int           lat;
        logic         ok;
        req = '{msg_type: t, opaque: op, addr: addr, len: len, data: data};
        do_txn(req, hold, resp, lat, ok);
        if (is_store(t)) begin
            model_write(addr, len, data);
            a_writes++;
        end else begin
            a_reads++;
        end
        if (ok) begin
            check({tag, "_type"},    64'(resp.msg_type), 64'(t));
            check({tag, "_opaque"},  64'(resp.opaque),   64'(op));
            check({tag, "_len"},     64'(resp.len),      64'(len));
            check({tag, "_test"},    64'(resp.test),     64'd0);
            check({tag, "_data"},    64'(resp.data),     64'(exp_data));
            check({tag, "_latency"}, 64'(lat),           64'd2);
        end
        $display("[TB] %s type=%0d addr=0x%08h len=%0d opaque=0x%02h resp_data=0x%08h lat=%0d",
                 tag, t, addr, len, op, resp.data, lat);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no summary, required summary");
        $fatal(1, "watchdog");
    end

    initial begin
        mem_req_4B_t b_stream [8];
        logic [31:0] b_exp    [8];
        int          seen;

        vecs[0]  = '{MEM_TYPE_WRITE, 32'h1000, 2'd0, 32'hdeadbeef, 8'h03, 32'h0};
        vecs[1]  = '{MEM_TYPE_READ,  32'h1000, 2'd0, 32'h0,        8'h04, 32'hdeadbeef};
        vecs[2]  = '{MEM_TYPE_WRITE, 32'h1002, 2'd1, 32'h000000aa, 8'h05, 32'h0};
        vecs[3]  = '{MEM_TYPE_READ,  32'h1000, 2'd0, 32'h0,        8'h06, 32'hdeaabeef};
        vecs[4]  = '{MEM_TYPE_READ,  32'h1002, 2'd2, 32'h0,        8'h07, 32'h0000deaa};
        vecs[5]  = '{MEM_TYPE_READ,  32'h1001, 2'd1, 32'h0,        8'h08, 32'h000000be};
        vecs[6]  = '{MEM_TYPE_READ,  32'h1003, 2'd1, 32'h0,        8'h09, 32'h000000de};
        vecs[7]  = '{MEM_TYPE_READ,  32'h1000, 2'd3, 32'h0,        8'h0a, 32'h00aabeef};
        vecs[8]  = '{MEM_TYPE_WRITE, 32'h0400, 2'd0, 32'h12345678, 8'h0b, 32'h0};
        vecs[9]  = '{MEM_TYPE_READ,  32'h0000, 2'd0, 32'h0,        8'h0c, 32'h12345678};
        vecs[10] = '{MEM_TYPE_INIT,  32'h2010, 2'd0, 32'hcafef00d, 8'h0d, 32'h0};
        vecs[11] = '{MEM_TYPE_READ,  32'h2010, 2'd2, 32'h0,        8'h0e, 32'h0000f00d};
        vecs[12] = '{MEM_TYPE_WRITE, 32'h2012, 2'd2, 32'h00001234, 8'h0f, 32'h0};
        vecs[13] = '{MEM_TYPE_READ,  32'h2010, 2'd0, 32'h0,        8'h10, 32'h1234f00d};
        vecs[14] = '{MEM_TYPE_WRITE, 32'h2010, 2'd3, 32'hffabcdef, 8'h11, 32'h0};
        vecs[15] = '{MEM_TYPE_READ,  32'h2010, 2'd0, 32'h0,        8'h12, 32'h12abcdef};
        vecs[16] = '{MEM_TYPE_READ,  32'h2012, 2'd2, 32'h0,        8'h13, 32'h000012ab};
        vecs[17] = '{MEM_TYPE_WRITE, 32'h2011, 2'd1, 32'h00000077, 8'h14, 32'h0};
        vecs[18] = '{MEM_TYPE_READ,  32'h2010, 2'd0, 32'h0,        8'h15, 32'h12ab77ef};

        for (int k = 0; k < 8; k++) begin
            if (k < 4) begin
                b_stream[k] = '{msg_type: MEM_TYPE_WRITE, opaque: 8'(8'h40 + k),
                                addr: 32'(32'h40 + 4 * k), len: 2'd0, data: 32'(32'ha5000000 + k)};
                b_exp[k]    = 32'h0;
            end else begin
                b_stream[k] = '{msg_type: MEM_TYPE_READ, opaque: 8'(8'h40 + k),
                                addr: 32'(32'h40 + 4 * (k - 4)), len: 2'd0, data: 32'h0};
                b_exp[k]    = 32'(32'ha5000000 + k - 4);
            end
        end

        a_req_val = 1'b0; a_resp_rdy = 1'b0; a_req_msg = '0;
        b_req_val = 1'b0; b_resp_rdy = 1'b0; b_req_msg = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_a_resp_val", 64'(a_resp_val), 64'd0);
        check("reset_a_req_rdy",  64'(a_req_rdy),  64'd1);
        check("reset_a_resp_msg", 64'(a_resp_msg), 64'd0);
        check("reset_b_resp_val", 64'(b_resp_val), 64'd0);
        check("reset_b_req_rdy",  64'(b_req_rdy),  64'd1);

        // Directed vector table.
        for (int i = 0; i < 19; i++)
            apply($sformatf("vec%0d", i), vecs[i].t, vecs[i].addr, vecs[i].len,
                  vecs[i].data, vecs[i].op, 0, vecs[i].exp);

        // Response held under backpressure for 5 cycles.
        apply("hold5", MEM_TYPE_READ, 32'h1000, 2'd0, 32'h0, 8'h20, 5, 32'h12345678);

`ifdef LAB2_PROC_MEM_RESPONDER_STATS_EN
        check("stats_reads",  64'(a_num_reads),  64'(a_reads));
        check("stats_writes", 64'(a_num_writes), 64'(a_writes));
`endif

        // Latency 0: back-to-back stream, one response per cycle in order.
        b_resp_rdy = 1'b1;
        b_req_val  = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            if (k > 0) begin
                check($sformatf("b2b%0d_val", k - 1),    64'(b_resp_val),        64'd1);
                check($sformatf("b2b%0d_opaque", k - 1), 64'(b_resp_msg.opaque), 64'(b_stream[k-1].opaque));
                check($sformatf("b2b%0d_data", k - 1),   64'(b_resp_msg.data),   64'(b_exp[k-1]));
                $display("[TB] b2b%0d opaque=0x%02h resp_data=0x%08h", k - 1, b_resp_msg.opaque, b_resp_msg.data);
            end
            if (k < 8) begin
                b_req_msg = b_stream[k];
                #1;
                check($sformatf("b2b%0d_req_rdy", k), 64'(b_req_rdy), 64'd1);
            end else begin
                b_req_val = 1'b0;
            end
            @(negedge clk);
        end
        check("b2b_drain_val", 64'(b_resp_val), 64'd0);
        b_resp_rdy = 1'b0;

        // Reset while a read sits in DELAY: nothing may come out.
        a_req_msg = '{msg_type: MEM_TYPE_READ, opaque: 8'h55, addr: 32'h1000, len: 2'd0, data: 32'h0};
        a_req_val = 1'b1;
        #1;
        check("rstdelay_req_rdy", 64'(a_req_rdy), 64'd1);
        @(posedge clk);
        @(negedge clk);
        a_req_val = 1'b0;
        check("rstdelay_in_delay_val", 64'(a_resp_val), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (a_resp_val) seen++;
        end
        check("rstdelay_no_resp", 64'(seen), 64'd0);
        check("rstdelay_req_rdy_after", 64'(a_req_rdy), 64'd1);
        $display("[TB] reset-in-delay read opaque=0x55 responses_seen=%0d", seen);
`ifdef LAB2_PROC_MEM_RESPONDER_STATS_EN
        check("rstdelay_num_reads",  64'(a_num_reads),  64'd0);
        check("rstdelay_num_writes", 64'(a_num_writes), 64'd0);
`endif
        a_reads  = 0;
        a_writes = 0;
        // Storage survives reset.
        apply("post_reset", MEM_TYPE_READ, 32'h1000, 2'd0, 32'h0, 8'h56, 0, 32'h12345678);

        // Fill every word, then random traffic against the model.
        for (int i = 0; i < 256; i++)
            apply($sformatf("fill%0d", i), MEM_TYPE_INIT, 32'(($urandom << 10) | (i * 4)),
                  2'd0, $urandom, 8'(i), 0, 32'h0);
        for (int i = 0; i < 80; i++) begin
            logic [2:0]  t;
            logic [31:0] addr;
            logic [1:0]  len;
            int          r;
            r    = int'($urandom_range(0, 3));
            t    = (r < 2) ? MEM_TYPE_READ : ((r == 2) ? MEM_TYPE_WRITE : MEM_TYPE_INIT);
            addr = $urandom;
            len  = 2'($urandom_range(0, 3));
            apply($sformatf("rand%0d", i), t, addr, len, $urandom, 8'($urandom),
                  int'($urandom_range(0, 2)),
                  (t == MEM_TYPE_READ) ? model_read(addr, len) : 32'h0);
        end

`ifdef LAB2_PROC_MEM_RESPONDER_STATS_EN
        check("final_num_reads",  64'(a_num_reads),  64'(a_reads));
        check("final_num_writes", 64'(a_num_writes), 64'(a_writes));
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
